// File: rtl/rom_banked_rd.sv
// rom_banked_rd: read-only memory built from BANKS single-port ROM macro banks.
// A valid/ready request port raises CE on the addressed bank only. A small
// in-order response buffer behind the macros absorbs consumer backpressure
// without losing full one-read-per-cycle throughput.
//
// Build option: define OUTREG_EN to capture macro Q in an extra register before
// the buffer (latency 2, 3-entry buffer). The default build (OUTREG_EN undefined)
// has latency 1 and a 2-entry buffer.
//
// Bank b holds hex-image lines HEX_BASE + b*BANK_DEPTH onward. The image is bound
// to the macro views by the memory flow, so the RTL only checks the value.

// Behavioural view of one single-port ROM macro. CE is high-valid and Q updates
// on the clock edge that samples CE. Q holds its last value otherwise. The write
// port exists on the macro but is tied off to read-only use by the wrapper.
module rom_banked_rd_macro #(
    parameter int DW    = 36,
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // NOTE: macro storage has no reset; its contents come from the ROM image.
    logic [DW-1:0] mem [DEPTH];

    // Macro access: registered read on every CE, optional write (tied off here).
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples the
        // pre-edge values of its inputs, independent of statement order.
        if (ce) begin
            if (we) begin
                mem[addr] <= d;
            end
            q <= mem[addr];
        end
    end

endmodule

module rom_banked_rd #(
    parameter int DW         = 36,
    parameter int BANK_DEPTH = 8192,
    parameter int BANKS      = 4,
    parameter int HEX_BASE   = 0,
    localparam int BAW       = $clog2(BANK_DEPTH),
    localparam int AW        = $clog2(BANK_DEPTH * BANKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DW-1:0]    resp_data,
    output logic [BANKS-1:0] bank_ce
);

    // Bank index width. It is kept at least 1 bit so a single-bank build still
    // has a legal select signal.
    localparam int BKW = (BANKS > 1) ? $clog2(BANKS) : 1;

    // Entries the response path can hold: the buffer slots plus whatever is
    // still travelling through the macro / capture stages.
`ifdef OUTREG_EN
    localparam int BUF_DEPTH = 3;
`else
    localparam int BUF_DEPTH = 2;
`endif
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    // Parameter sanity: the address split assumes power-of-two geometry.
    if ((BANK_DEPTH < 2) || ((BANK_DEPTH & (BANK_DEPTH - 1)) != 0) ||
        (BANKS < 1) || ((BANKS & (BANKS - 1)) != 0) || (HEX_BASE < 0)) begin : g_bad_params
        $error("rom_banked_rd: BANK_DEPTH/BANKS must be powers of two and HEX_BASE non-negative");
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [BKW-1:0] bank_sel;
    logic [BAW-1:0] row;
    logic           fire;

    assign row  = req_addr[BAW-1:0];
    assign fire = req_valid && req_ready;

    if (BANKS > 1) begin : g_multi_bank
        assign bank_sel = req_addr[AW-1:BAW];
    end else begin : g_single_bank
        assign bank_sel = '0;
    end

    // Raise CE only on the addressed bank, and only for an accepted request.
    always_comb begin
        // NOTE: default first so every path assigns bank_ce and no latch is inferred.
        bank_ce = '0;
        if (fire) begin
            bank_ce[bank_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Macro banks: shared row address, per-bank CE, write port tied off.
    // ------------------------------------------------------------------
    logic [DW-1:0] bank_q [BANKS];

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        rom_banked_rd_macro #(
            .DW    (DW),
            .DEPTH (BANK_DEPTH),
            .AW    (BAW)
        ) u_macro (
            .clk  (clk),
            .ce   (bank_ce[b]),
            .we   (1'b0),
            .addr (row),
            .d    ('0),
            .q    (bank_q[b])
        );
    end

    // ------------------------------------------------------------------
    // Issue stage: remember that a read was launched and which bank's Q
    // carries it on the following cycle.
    // ------------------------------------------------------------------
    logic           rd_pend;
    logic [BKW-1:0] rd_bank;
    logic [DW-1:0]  q_sel;

    // Track the read launched this cycle. Reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_bank <= '0;
        end else begin
            rd_pend <= fire;
            if (fire) begin
                rd_bank <= bank_sel;
            end
        end
    end

    assign q_sel = bank_q[rd_bank];

    // ------------------------------------------------------------------
    // Buffer input stage: either the selected macro Q directly, or a
    // registered copy of it one cycle later.
    // ------------------------------------------------------------------
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [OW-1:0] inflight;

`ifdef OUTREG_EN
    logic          cap_valid;
    logic [DW-1:0] cap_data;

    // Capture macro Q so the buffer input sees a flop, not the macro output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= rd_pend;
            if (rd_pend) begin
                cap_data <= q_sel;
            end
        end
    end

    assign in_valid = cap_valid;
    assign in_data  = cap_data;
    assign inflight = OW'(rd_pend) + OW'(cap_valid);
`else
    assign in_valid = rd_pend;
    assign in_data  = q_sel;
    assign inflight = OW'(rd_pend);
`endif

    // ------------------------------------------------------------------
    // Response buffer: in-order circular FIFO. When it is empty, the entry
    // arriving at its input is presented directly as the head, so a read
    // can be consumed on the cycle its data appears. If that entry is not
    // consumed it is written into the buffer and stays the head, so data
    // and valid stay stable under backpressure.
    // ------------------------------------------------------------------
    logic [DW-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [OW-1:0] occ;
    logic          buf_empty;
    logic          pop;
    logic          push;
    logic          pop_buf;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign buf_empty  = (cnt == '0);
    assign resp_valid = !rst && (!buf_empty || in_valid);
    assign resp_data  = buf_empty ? in_data : buf_mem[rd_ptr];
    assign pop        = resp_valid && resp_ready;

    // An arriving entry is stored unless it was consumed straight through.
    assign push    = in_valid && !(buf_empty && pop);
    assign pop_buf = pop && !buf_empty;

    // Occupancy counts stored entries plus reads still in flight. A slot
    // freed by this cycle's pop may be reused by this cycle's request.
    assign occ       = OW'(cnt) + inflight;
    assign req_ready = !rst && ((occ - OW'(pop)) < OW'(BUF_DEPTH));

    // Buffer pointers and fill count. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_buf) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            cnt <= cnt + CW'(push) - CW'(pop_buf);
        end
    end

    // Buffer storage write. Entries are only read while counted, so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_rom_banked_rd.sv
// tb_rom_banked_rd: randomized and directed checks of rom_banked_rd against a
// transaction-level model. Every accepted request queues its expected word,
// which is computed from the image formula, and becomes visible LAT cycles
// later. Responses must match the queue head in order. req_ready follows the
// outstanding-count rule, and bank_ce must be the one-hot bank of an accepted
// request or zero.
`timescale 1ns/1ps

module tb_rom_banked_rd;

    localparam int DW         = 36;
    localparam int BANK_DEPTH = 8192;
    localparam int BANKS      = 4;
    localparam int HEX_BASE   = 0;
    localparam int BAW        = 13;
    localparam int AW         = 15;
`ifdef OUTREG_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 3;
`else
    localparam int LAT   = 1;
    localparam int DEPTH = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             resp_valid;
    logic             resp_ready;
    logic [DW-1:0]    resp_data;
    logic [BANKS-1:0] bank_ce;

    always #5 clk = ~clk;

    rom_banked_rd #(
        .DW         (DW),
        .BANK_DEPTH (BANK_DEPTH),
        .BANKS      (BANKS),
        .HEX_BASE   (HEX_BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .bank_ce    (bank_ce)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM image word at a given hex line. One line holds a fixed known value.
    function automatic logic [DW-1:0] image_word(input int line);
        logic [31:0] h;
        if (line == HEX_BASE + 2 * BANK_DEPTH + 5) begin
            return 36'h9_ABCD_1234;
        end
        h = line * 32'h9E37_79B1 + 32'h0BAD_F00D;
        return {line[3:0] ^ h[31:28], h};
    endfunction

    // Preload every bank with its slice of the image.
    for (genvar b = 0; b < BANKS; b++) begin : g_load
        initial begin
            for (int r = 0; r < BANK_DEPTH; r++) begin
                dut.g_bank[b].u_macro.mem[BAW'(r)] = image_word(HEX_BASE + b * BANK_DEPTH + r);
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   resp_cnt;
    int   first_resp;
    int   last_resp;

    // Mid-cycle sample: compare the DUT against the model, then advance the model.
    task automatic half();
        logic             exp_valid;
        logic             mpop;
        logic             fire;
        logic [BANKS-1:0] exp_ce;
        @(negedge clk);
        if (!rst) begin
            exp_valid = (exp_q.size() > 0) && ((cyc - exp_q[0].t) >= LAT);
            mpop      = exp_valid && resp_ready;
            check("resp_valid", 64'(resp_valid), 64'(exp_valid));
            if (resp_valid && exp_valid) begin
                check("resp_data", 64'(resp_data), 64'(exp_q[0].data));
            end
            check("req_ready", 64'(req_ready), 64'((exp_q.size() - int'(mpop)) < DEPTH));
            fire   = req_valid && req_ready;
            exp_ce = '0;
            if (fire) begin
                exp_ce = BANKS'(1) << req_addr[AW-1:BAW];
            end
            check("bank_ce", 64'(bank_ce), 64'(exp_ce));
            if (mpop) begin
                exp_q.delete(0);
                resp_cnt++;
                if (first_resp < 0) begin
                    first_resp = cyc;
                end
                last_resp = cyc;
            end
            if (fire) begin
                exp_q.push_back('{data: image_word(HEX_BASE + int'(req_addr)), t: cyc});
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int bound);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < bound && exp_q.size() > 0; i++) begin
            half();
            next();
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    logic [AW-1:0] bp_addr [4];
    logic [DW-1:0] head_exp;
    int            acc;
    bit            took;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_addr   = '0;
        resp_ready = 1'b0;
        resp_cnt   = 0;
        first_resp = -1;
        last_resp  = -1;

        // Reset held with a request offered: nothing accepted, nothing returned.
        for (int i = 0; i < 5; i++) begin
            half();
            check("rst_bank_ce", 64'(bank_ce), 64'(0));
            check("rst_resp_valid", 64'(resp_valid), 64'(0));
            check("rst_req_ready", 64'(req_ready), 64'(0));
            next();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        half();
        check("rst_release_ready", 64'(req_ready), 64'(1));
        next();

        // Single read of bank 2, row 5.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = {2'd2, 13'h005};
        half();
        check("single_ce", 64'(bank_ce), 64'(4'b0100));
        next();
        req_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            half();
            check("single_wait", 64'(resp_valid), 64'(0));
            next();
        end
        half();
        check("single_valid", 64'(resp_valid), 64'(1));
        check("single_data", 64'(resp_data), 64'(36'h9_ABCD_1234));
        next();
        half();
        check("single_done", 64'(resp_valid), 64'(0));
        next();

        // Streaming addresses 0..63 with an always-ready consumer.
        resp_cnt   = 0;
        first_resp = -1;
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(i);
            half();
            check("stream_ready", 64'(req_ready), 64'(1));
            next();
        end
        drain(50);
        check("stream_count", 64'(resp_cnt), 64'(64));
        check("stream_span", 64'(last_resp - first_resp), 64'(63));

        // Backpressure: four requests offered, consumer stalled.
        for (int i = 0; i < 4; i++) begin
            bp_addr[i] = AW'($urandom);
        end
        head_exp   = image_word(HEX_BASE + int'(bp_addr[0]));
        resp_ready = 1'b0;
        resp_cnt   = 0;
        acc        = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = bp_addr[acc < 4 ? acc : 3];
            half();
            if (req_valid && req_ready) begin
                acc++;
            end
            if (resp_valid) begin
                check("bp_head", 64'(resp_data), 64'(head_exp));
            end
            next();
        end
        check("bp_accepted", 64'(acc), 64'(DEPTH));
        req_addr = bp_addr[acc < 4 ? acc : 3];
        half();
        check("bp_ready_low", 64'(req_ready), 64'(0));
        check("bp_head_held", 64'(resp_data), 64'(head_exp));
        next();
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            req_valid = 1'b1;
            req_addr  = bp_addr[acc];
            half();
            if (req_valid && req_ready) begin
                acc++;
            end
            next();
        end
        check("bp_all_accepted", 64'(acc), 64'(4));
        drain(50);
        check("bp_resp_count", 64'(resp_cnt), 64'(4));

        // Reset one cycle after a request fires: that read must vanish.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = AW'($urandom);
        half();
        next();
        rst       = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        half();
        check("mid_rst_valid", 64'(resp_valid), 64'(0));
        next();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            half();
            check("mid_no_resp", 64'(resp_valid), 64'(0));
            next();
        end

        // Random traffic. The source holds an offered request until it is taken.
        took = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if (!req_valid || took) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_addr  = AW'($urandom);
            end
            resp_ready = 1'($urandom_range(0, 1));
            half();
            took = req_valid && req_ready;
            next();
        end
        drain(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
